result_writeback: RTL and testbench

Parametrised successor to the conv result writer. Accepts one beat of LANES parallel accumulator results (LANES consecutive output pixels of one kernel) over a valid/ready handshake and requantises each lane (arithmetic shift, optional rounding, optional ReLU, saturation). It then serialises the lanes into single-word memory writes with internally generated addresses, masking tail lanes past the feature-map end. It sits between the GEMM array output and the output-feature SRAM and replaces fixed S2P_SIZE/DATA_WIDTH constants with parameters plus a runtime config latched at start.

---
 rtl/result_writeback_pkg.sv | 28 ++
 rtl/result_writeback_wb_requant.sv | 38 +++
 rtl/result_writeback.sv | 173 +++++++++++++++++
 tb/tb_result_writeback.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_writeback_pkg.sv
// Shared types and helpers for the result writeback block.
// Build option: WB_ROUND_EN enables round-half-up requantisation.
package result_writeback_pkg;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      WRITE,
      DONE
   } wb_state_t;

   function automatic int lane_lo(input int lane, input int width);
      return lane * width;
   endfunction

   function automatic longint sat_max(input int dw);
      return (longint'(1) << (dw - 1)) - 1;
   endfunction

   function automatic longint sat_min(input int dw);
      return -(longint'(1) << (dw - 1));
   endfunction

   localparam int     DEF_DATA_WIDTH = 8;
   localparam longint SAT_MAX = sat_max(DEF_DATA_WIDTH);
   localparam longint SAT_MIN = sat_min(DEF_DATA_WIDTH);

endpackage

// File: rtl/result_writeback_wb_requant.sv
// One-lane requantiser: shift, optional rounding, ReLU, saturation.
// Build option: WB_ROUND_EN adds 2^(shift-1) before the shift.
module wb_requant
   import result_writeback_pkg::*;
#(
   parameter int ACC_WIDTH   = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic signed [ACC_WIDTH-1:0]   acc,
   input  logic        [SHIFT_WIDTH-1:0] shift,
   input  logic                          relu,
   output logic        [DATA_WIDTH-1:0]  q
);

   localparam int EW = ACC_WIDTH + 1;
   localparam logic signed [EW-1:0] SMAX = EW'(sat_max(DATA_WIDTH));
   localparam logic signed [EW-1:0] SMIN = EW'(sat_min(DATA_WIDTH));

   logic signed [EW-1:0] ext;
   logic signed [EW-1:0] rnd;
   logic signed [EW-1:0] s;

   always_comb begin
      ext = {acc[ACC_WIDTH-1], acc};
      rnd = '0;
`ifdef WB_ROUND_EN
      if (shift != '0) rnd = EW'(1) << (shift - 1'b1);
`endif
      // extra headroom bit keeps the rounding add from overflowing
      s = (ext + rnd) >>> shift;
      if (relu && s < 0) s = '0;
      if (s > SMAX)      q = SMAX[DATA_WIDTH-1:0];
      else if (s < SMIN) q = SMIN[DATA_WIDTH-1:0];
      else               q = s[DATA_WIDTH-1:0];
   end

endmodule

// File: rtl/result_writeback.sv
// Accepts LANES accumulator results per beat, requantises, writes serially.
// Build option: WB_ROUND_EN selects rounding requantisation.
module result_writeback
   import result_writeback_pkg::*;
#(
   parameter int LANES       = 4,
   parameter int ACC_WIDTH   = 32,
   parameter int DATA_WIDTH  = 8,
   parameter int ADDR_WIDTH  = 16,
   parameter int KCNT_WIDTH  = 8,
   parameter int SHIFT_WIDTH = 5
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic [ADDR_WIDTH-1:0]        cfg_base_addr,
   input  logic [ADDR_WIDTH-1:0]        cfg_o_feature_size,
   input  logic [KCNT_WIDTH-1:0]        cfg_num_kernels,
   input  logic [SHIFT_WIDTH-1:0]       cfg_shift,
   input  logic                         cfg_relu,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [LANES*ACC_WIDTH-1:0]   in_data,
   output logic                         mem_we,
   output logic [ADDR_WIDTH-1:0]        mem_addr,
   output logic [DATA_WIDTH-1:0]        mem_wdata,
   input  logic                         mem_gnt,
   output logic                         busy,
   output logic                         done
);

   localparam int LW  = $clog2(LANES + 1);
   localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int AW1 = ADDR_WIDTH + 1;

   wb_state_t              state;
   logic [ADDR_WIDTH-1:0]  base_r;
   logic [ADDR_WIDTH-1:0]  fs_r;
   logic [ADDR_WIDTH-1:0]  p_r;
   logic [ADDR_WIDTH-1:0]  kfs_r;
   logic [KCNT_WIDTH-1:0]  nk_r;
   logic [KCNT_WIDTH-1:0]  k_r;
   logic [SHIFT_WIDTH-1:0] shift_r;
   logic                   relu_r;
   logic [LIW-1:0]         lane_r;
   logic [LW-1:0]          n_r;
   logic [DATA_WIDTH-1:0]  q_r [LANES];
   logic [DATA_WIDTH-1:0]  q_c [LANES];

   logic                   last_lane;
   logic                   last_k;
   logic                   grp_end;
   logic                   beat_end;
   logic                   layer_end;
   logic                   accept;
   logic [ADDR_WIDTH-1:0]  p_nxt;
   logic [ADDR_WIDTH-1:0]  p_acc;
   logic [ADDR_WIDTH-1:0]  rem;
   logic [LW-1:0]          n_acc;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      wb_requant #(
         .ACC_WIDTH  (ACC_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .SHIFT_WIDTH(SHIFT_WIDTH)
      ) u_rq (
         .acc  (in_data[lane_lo(i, ACC_WIDTH) +: ACC_WIDTH]),
         .shift(shift_r),
         .relu (relu_r),
         .q    (q_c[i])
      );
   end

   always_comb begin
      last_lane = (LW'(lane_r) == n_r - 1'b1);
      last_k    = (k_r == nk_r - 1'b1);
      grp_end   = ({1'b0, p_r} + AW1'(LANES)) >= {1'b0, fs_r};
      beat_end  = (state == WRITE) && mem_gnt && last_lane;
      layer_end = beat_end && last_k && grp_end;
      p_nxt     = last_k ? p_r + ADDR_WIDTH'(LANES) : p_r;
      // a beat taken on the final grant belongs to the next kernel/group
      p_acc     = (state == WRITE) ? p_nxt : p_r;
      rem       = fs_r - p_acc;
      n_acc     = (rem >= ADDR_WIDTH'(LANES)) ? LW'(LANES) : LW'(rem);
      in_ready  = (state == RUN) || (beat_end && !layer_end);
      accept    = in_valid && in_ready;
      mem_we    = (state == WRITE);
      mem_addr  = base_r + kfs_r + p_r + ADDR_WIDTH'(lane_r);
      mem_wdata = q_r[lane_r];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         base_r  <= '0;
         fs_r    <= '0;
         p_r     <= '0;
         kfs_r   <= '0;
         nk_r    <= '0;
         k_r     <= '0;
         shift_r <= '0;
         relu_r  <= 1'b0;
         lane_r  <= '0;
         n_r     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         for (int i = 0; i < LANES; i++) q_r[i] <= '0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  base_r  <= cfg_base_addr;
                  fs_r    <= cfg_o_feature_size;
                  nk_r    <= cfg_num_kernels;
                  shift_r <= cfg_shift;
                  relu_r  <= cfg_relu;
                  k_r     <= '0;
                  p_r     <= '0;
                  kfs_r   <= '0;
                  if (cfg_num_kernels == '0 ||
                      cfg_o_feature_size == '0) begin
                     state <= DONE;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (accept) begin
                  for (int i = 0; i < LANES; i++) q_r[i] <= q_c[i];
                  lane_r <= '0;
                  n_r    <= n_acc;
                  state  <= WRITE;
               end
            end
            WRITE: begin
               if (mem_gnt) begin
                  if (!last_lane) begin
                     lane_r <= lane_r + 1'b1;
                  end else begin
                     p_r <= p_nxt;
                     if (last_k) begin
                        k_r   <= '0;
                        kfs_r <= '0;
                     end else begin
                        k_r   <= k_r + 1'b1;
                        kfs_r <= kfs_r + fs_r;
                     end
                     if (layer_end) begin
                        state <= DONE;
                        busy  <= 1'b0;
                     end else if (accept) begin
                        for (int i = 0; i < LANES; i++) q_r[i] <= q_c[i];
                        lane_r <= '0;
                        n_r    <= n_acc;
                     end else begin
                        state <= RUN;
                     end
                  end
               end
            end
            DONE: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_result_writeback.sv
// Directed self-checking bench for result_writeback (LANES=4).
module tb_result_writeback;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [15:0]  cfg_base_addr;
   logic [15:0]  cfg_o_feature_size;
   logic [7:0]   cfg_num_kernels;
   logic [4:0]   cfg_shift;
   logic         cfg_relu;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic         mem_we;
   logic [15:0]  mem_addr;
   logic [7:0]   mem_wdata;
   logic         mem_gnt;
   logic         busy;
   logic         done;

   int n_checks = 0;
   int n_pass   = 0;
   int done_cnt = 0;
   int cyc      = 0;
   bit timed_out;

   logic [15:0]  wq_a[$];
   logic [7:0]   wq_d[$];
   int           wq_c[$];
   logic [127:0] beat_mem[8];

`ifdef WB_ROUND_EN
   localparam bit RND = 1'b1;
`else
   localparam bit RND = 1'b0;
`endif

   result_writeback dut (
      .clk               (clk),
      .rst               (rst),
      .start             (start),
      .cfg_base_addr     (cfg_base_addr),
      .cfg_o_feature_size(cfg_o_feature_size),
      .cfg_num_kernels   (cfg_num_kernels),
      .cfg_shift         (cfg_shift),
      .cfg_relu          (cfg_relu),
      .in_valid          (in_valid),
      .in_ready          (in_ready),
      .in_data           (in_data),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_gnt           (mem_gnt),
      .busy              (busy),
      .done              (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (done === 1'b1) done_cnt <= done_cnt + 1;
      if (mem_we === 1'b1 && mem_gnt === 1'b1) begin
         wq_a.push_back(mem_addr);
         wq_d.push_back(mem_wdata);
         wq_c.push_back(cyc);
      end
   end

   function automatic logic [127:0] mk(int a0, int a1, int a2, int a3);
      return {32'(a3), 32'(a2), 32'(a1), 32'(a0)};
   endfunction

   task automatic send_beat(input logic [127:0] d, output bit to);
      int c;
      c = 0;
      to = 1'b0;
      in_data = d;
      in_valid = 1'b1;
      while (1) begin
         @(negedge clk);
         if (in_ready === 1'b1) break;
         c++;
         if (c > 100) begin
            to = 1'b1;
            break;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_layer(input logic [15:0] base, input logic [15:0] fs,
                            input logic [7:0] nk, input logic [4:0] sh,
                            input bit rl, input int nb);
      bit to;
      int c;
      wq_a.delete();
      wq_d.delete();
      wq_c.delete();
      done_cnt = 0;
      timed_out = 1'b0;
      @(posedge clk);
      #1;
      cfg_base_addr = base;
      cfg_o_feature_size = fs;
      cfg_num_kernels = nk;
      cfg_shift = sh;
      cfg_relu = rl;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int b = 0; b < nb; b++) begin
         send_beat(beat_mem[b], to);
         if (to) timed_out = 1'b1;
      end
      in_valid = 1'b0;
      c = 0;
      while (done_cnt == 0 && c < 300) begin
         @(negedge clk);
         c++;
      end
      if (done_cnt == 0) timed_out = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({mem_we, busy, done, in_ready} !== 4'b0 ||
          mem_addr !== 16'h0 || mem_wdata !== 8'h0)
         $display("FAIL reset_outputs: we/busy/done/rdy=%b addr=%h data=%h want 0",
                  {mem_we, busy, done, in_ready}, mem_addr, mem_wdata);
      else n_pass++;
      rst = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b0)
         $display("FAIL idle_ready: got %b want 0", in_ready);
      else n_pass++;
      in_valid = 1'b0;
   endtask

   task automatic test_layer();
      int idx;
      int n;
      logic [15:0] ea;
      for (int b = 0; b < 6; b++)
         beat_mem[b] = mk((b*4)*8, (b*4+1)*8, (b*4+2)*8, (b*4+3)*8);
      mem_gnt = 1'b1;
      run_layer(16'h0100, 16'd9, 8'd2, 5'd3, 1'b0, 6);
      n_checks++;
      if (timed_out) $display("FAIL layer_timeout: got 1 want 0");
      else n_pass++;
      n_checks++;
      if (wq_a.size() != 18)
         $display("FAIL layer_count: got %0d want 18", wq_a.size());
      else n_pass++;
      idx = 0;
      for (int b = 0; b < 6; b++) begin
         n = ((9 - (b/2)*4) < 4) ? (9 - (b/2)*4) : 4;
         for (int i = 0; i < n; i++) begin
            ea = 16'h0100 + 16'((b%2)*9 + (b/2)*4 + i);
            n_checks++;
            if (idx >= wq_a.size() || wq_a[idx] !== ea ||
                wq_d[idx] !== 8'(b*4+i))
               $display("FAIL layer_write%0d: got %h/%h want %h/%h", idx,
                        (idx < wq_a.size()) ? wq_a[idx] : 16'hxxxx,
                        (idx < wq_d.size()) ? wq_d[idx] : 8'hxx,
                        ea, 8'(b*4+i));
            else n_pass++;
            idx++;
         end
      end
      n_checks++;
      if (wq_c.size() != 18 || wq_c[17] - wq_c[0] != 17)
         $display("FAIL back_to_back: got span %0d want 17",
                  (wq_c.size() == 18) ? wq_c[17] - wq_c[0] : -1);
      else n_pass++;
      n_checks++;
      if (done_cnt != 1 || busy !== 1'b0)
         $display("FAIL layer_done: got done_cnt=%0d busy=%b want 1/0",
                  done_cnt, busy);
      else n_pass++;
   endtask

   task automatic test_quant();
      int e[4];
      beat_mem[0] = mk(1000, 1100, -1100, 8);
      run_layer(16'h0040, 16'd4, 8'd1, 5'd3, 1'b0, 1);
      e = '{125, 127, -128, 1};
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wq_d.size() != 4 || wq_d[i] !== 8'(e[i]) ||
             wq_a[i] !== 16'h0040 + 16'(i))
            $display("FAIL quant_sh3_l%0d: got %h want %h", i,
                     (wq_d.size() > i) ? wq_d[i] : 8'hxx, 8'(e[i]));
         else n_pass++;
      end
      beat_mem[0] = mk(-2000, 14, 5, -1);
      run_layer(16'h0050, 16'd4, 8'd1, 5'd2, 1'b0, 1);
      e = '{-128, RND ? 4 : 3, 1, RND ? 0 : -1};
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wq_d.size() != 4 || wq_d[i] !== 8'(e[i]))
            $display("FAIL quant_sh2_l%0d: got %h want %h", i,
                     (wq_d.size() > i) ? wq_d[i] : 8'hxx, 8'(e[i]));
         else n_pass++;
      end
      run_layer(16'h0060, 16'd4, 8'd1, 5'd2, 1'b1, 1);
      e = '{0, RND ? 4 : 3, 1, 0};
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wq_d.size() != 4 || wq_d[i] !== 8'(e[i]))
            $display("FAIL quant_relu_l%0d: got %h want %h", i,
                     (wq_d.size() > i) ? wq_d[i] : 8'hxx, 8'(e[i]));
         else n_pass++;
      end
   endtask

   task automatic test_round();
      int e[4];
      beat_mem[0] = mk(-6, 7, 0, -1);
      run_layer(16'h0070, 16'd4, 8'd1, 5'd1, 1'b0, 1);
      e = '{-3, RND ? 4 : 3, 0, RND ? 0 : -1};
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wq_d.size() != 4 || wq_d[i] !== 8'(e[i]))
            $display("FAIL round_sh1_l%0d: got %h want %h", i,
                     (wq_d.size() > i) ? wq_d[i] : 8'hxx, 8'(e[i]));
         else n_pass++;
      end
      beat_mem[0] = mk(100, -200, 300, -5);
      run_layer(16'h0080, 16'd4, 8'd1, 5'd0, 1'b0, 1);
      e = '{100, -128, 127, -5};
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (wq_d.size() != 4 || wq_d[i] !== 8'(e[i]))
            $display("FAIL shift0_l%0d: got %h want %h", i,
                     (wq_d.size() > i) ? wq_d[i] : 8'hxx, 8'(e[i]));
         else n_pass++;
      end
   endtask

   task automatic test_stall();
      beat_mem[0] = mk(10, 11, 12, 13);
      beat_mem[1] = mk(14, 15, 16, 17);
      mem_gnt = 1'b1;
      fork
         run_layer(16'h0200, 16'd8, 8'd1, 5'd0, 1'b0, 2);
         begin
            int c;
            int idx;
            bit got;
            c = 0;
            got = 1'b0;
            while (c < 100) begin
               @(posedge clk);
               #2;
               if (wq_a.size() >= 2) begin
                  got = 1'b1;
                  break;
               end
               c++;
            end
            n_checks++;
            if (!got) $display("FAIL stall_reach: got 0 want 1");
            else n_pass++;
            if (got) begin
               idx = wq_a.size();
               mem_gnt = 1'b0;
               repeat (3) begin
                  @(negedge clk);
                  n_checks++;
                  if (mem_we !== 1'b1 || mem_addr !== 16'h0200 + 16'(idx) ||
                      mem_wdata !== 8'(10 + idx) || in_ready !== 1'b0)
                     $display("FAIL stall_hold: got we=%b a=%h d=%h rdy=%b want 1/%h/%h/0",
                              mem_we, mem_addr, mem_wdata, in_ready,
                              16'h0200 + 16'(idx), 8'(10 + idx));
                  else n_pass++;
               end
               mem_gnt = 1'b1;
            end
         end
      join
      n_checks++;
      if (wq_a.size() != 8 || timed_out)
         $display("FAIL stall_count: got %0d want 8", wq_a.size());
      else n_pass++;
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (i >= wq_a.size() || wq_a[i] !== 16'h0200 + 16'(i) ||
             wq_d[i] !== 8'(10 + i))
            $display("FAIL stall_write%0d: got %h want %h", i,
                     (i < wq_a.size()) ? wq_a[i] : 16'hxxxx, 16'h0200 + 16'(i));
         else n_pass++;
      end
   endtask

   task automatic test_empty();
      wq_a.delete();
      wq_d.delete();
      wq_c.delete();
      done_cnt = 0;
      @(posedge clk);
      #1;
      cfg_num_kernels = 8'd0;
      cfg_o_feature_size = 16'd5;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      n_checks++;
      if (done !== 1'b0) $display("FAIL empty_done_early: got %b want 0", done);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b1) $display("FAIL empty_done: got %b want 1", done);
      else n_pass++;
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0 || wq_a.size() != 0)
         $display("FAIL empty_after: got done=%b busy=%b writes=%0d want 0/0/0",
                  done, busy, wq_a.size());
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      bit to;
      bit any_to;
      any_to = 1'b0;
      done_cnt = 0;
      mem_gnt = 1'b1;
      beat_mem[0] = mk(1, 2, 3, 4);
      beat_mem[1] = mk(5, 6, 7, 8);
      @(posedge clk);
      #1;
      cfg_base_addr = 16'h0280;
      cfg_o_feature_size = 16'd8;
      cfg_num_kernels = 8'd1;
      cfg_shift = 5'd0;
      cfg_relu = 1'b0;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      send_beat(beat_mem[0], to);
      any_to |= to;
      send_beat(beat_mem[1], to);
      any_to |= to;
      in_valid = 1'b0;
      n_checks++;
      if (any_to || mem_we !== 1'b1)
         $display("FAIL midrst_setup: got we=%b want 1", mem_we);
      else n_pass++;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mem_we, busy, done, in_ready} !== 4'b0 ||
          mem_addr !== 16'h0 || mem_wdata !== 8'h0)
         $display("FAIL midrst_outputs: got %b a=%h d=%h want 0",
                  {mem_we, busy, done, in_ready}, mem_addr, mem_wdata);
      else n_pass++;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (done_cnt != 0) $display("FAIL midrst_nodone: got %0d want 0", done_cnt);
      else n_pass++;
      beat_mem[0] = mk(21, 22, 23, 24);
      run_layer(16'h0300, 16'd4, 8'd1, 5'd0, 1'b0, 1);
      n_checks++;
      if (timed_out || wq_a.size() != 4 || done_cnt != 1)
         $display("FAIL midrst_rerun: got writes=%0d done=%0d want 4/1",
                  wq_a.size(), done_cnt);
      else n_pass++;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (i >= wq_a.size() || wq_a[i] !== 16'h0300 + 16'(i) ||
             wq_d[i] !== 8'(21 + i))
            $display("FAIL midrst_write%0d: got %h want %h", i,
                     (i < wq_a.size()) ? wq_a[i] : 16'hxxxx, 16'h0300 + 16'(i));
         else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b1;
      start = 1'b0;
      cfg_base_addr = '0;
      cfg_o_feature_size = '0;
      cfg_num_kernels = '0;
      cfg_shift = '0;
      cfg_relu = 1'b0;
      in_valid = 1'b0;
      in_data = '0;
      mem_gnt = 1'b1;
      test_reset();
      test_layer();
      test_quant();
      test_round();
      test_stall();
      test_empty();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
